hier_lane_sequencer: RTL and testbench



---
 rtl/hier_lane_seq_pkg.sv | 41 ++++
 rtl/hier_lane_sequencer_if.sv | 39 +++
 rtl/hier_lane_seq_next.sv | 28 ++
 rtl/hier_lane_sequencer.sv | 127 ++++++++++++
 tb/tb_hier_lane_sequencer.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/hier_lane_seq_pkg.sv
// Shared types, widths and the lane word mux for the hier_lane_sequencer slice.
// Optional parity output is controlled by HIER_LANE_SEQ_PARITY_EN.
package hier_lane_seq_pkg;

    localparam int LANE_W  = 8;
    localparam int OP_W    = 4;
    localparam int N_LANES = 4;
    localparam int IDX_W   = 2;

    localparam logic [IDX_W-1:0] LANE_A = 2'd0;
    localparam logic [IDX_W-1:0] LANE_B = 2'd1;
    localparam logic [IDX_W-1:0] LANE_C = 2'd2;
    localparam logic [IDX_W-1:0] LANE_D = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Selects one of the four datapath result lanes.
    function automatic logic [LANE_W-1:0] laneWord(
        input logic [IDX_W-1:0]  sel,
        input logic [OP_W-1:0]   op_a,
        input logic [OP_W-1:0]   op_b,
        input logic [LANE_W-1:0] c_lane,
        input logic [LANE_W-1:0] d_lane,
        input logic              sext
    );
        logic [LANE_W-1:0] w;
        case (sel)
            LANE_A:  w = {{(LANE_W-OP_W){1'b0}}, op_a};
            LANE_B:  w = sext ? {{(LANE_W-OP_W){op_b[OP_W-1]}}, op_b}
                              : {{(LANE_W-OP_W){1'b0}}, op_b};
            LANE_C:  w = c_lane;
            default: w = d_lane;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/hier_lane_sequencer_if.sv
// Command and output-stream bundle for hier_lane_sequencer.
// out_par exists only when HIER_LANE_SEQ_PARITY_EN is defined.
interface hier_lane_sequencer_if;
    import hier_lane_seq_pkg::*;

    logic                start_valid;
    logic                start_ready;
    logic [OP_W-1:0]     a;
    logic [OP_W-1:0]     b;
    logic [N_LANES-1:0]  lane_mask;
    logic                flush;
    logic                out_valid;
    logic                out_ready;
    logic [LANE_W-1:0]   out_data;
    logic [IDX_W-1:0]    out_idx;
    logic                out_last;
    logic                done;
    logic                busy;
`ifdef HIER_LANE_SEQ_PARITY_EN
    logic                out_par;
`endif

    modport master (
        output start_valid, a, b, lane_mask, flush, out_ready,
`ifdef HIER_LANE_SEQ_PARITY_EN
        input  out_par,
`endif
        input  start_ready, out_valid, out_data, out_idx, out_last, done, busy
    );

    modport slave (
        input  start_valid, a, b, lane_mask, flush, out_ready,
`ifdef HIER_LANE_SEQ_PARITY_EN
        output out_par,
`endif
        output start_ready, out_valid, out_data, out_idx, out_last, done, busy
    );

endinterface

// File: rtl/hier_lane_seq_next.sv
// Mask scanner: lowest enabled lane, and the next enabled lane above a given index.
module hier_lane_seq_next
    import hier_lane_seq_pkg::*;
(
    input  logic [N_LANES-1:0] mask,
    input  logic [IDX_W-1:0]   cur,
    output logic [IDX_W-1:0]   next_idx,
    output logic               has_next,
    output logic [IDX_W-1:0]   low_idx
);

    // Scan downward so the lowest qualifying bit is the one that sticks.
    always_comb begin
        has_next = 1'b0;
        next_idx = cur;
        low_idx  = '0;
        for (int i = N_LANES - 1; i >= 0; i--) begin
            if (mask[i]) begin
                low_idx = IDX_W'(i);
            end
            if (mask[i] && (i > int'(cur))) begin
                has_next = 1'b1;
                next_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/hier_lane_sequencer.sv
// Captures (a, b, lane_mask) and streams the enabled lanes in ascending order.
// Define HIER_LANE_SEQ_PARITY_EN to add the registered out_par output.
module hier_lane_sequencer
    import hier_lane_seq_pkg::*;
#(
    parameter int          C_VAL  = 0,
    parameter logic [7:0]  D_VAL  = 8'h00,
    parameter int          B_SEXT = 0
)(
    input  logic                  clk,
    input  logic                  rst_n,
    hier_lane_sequencer_if.slave  bus
);

    localparam logic [LANE_W-1:0] C_LANE = LANE_W'(C_VAL);
    localparam logic [LANE_W-1:0] D_LANE = D_VAL;
    localparam logic              SEXT   = (B_SEXT != 0);

    state_t              state;
    state_t              state_nx;
    logic [OP_W-1:0]     cap_a;
    logic [OP_W-1:0]     cap_b;
    logic [N_LANES-1:0]  cap_mask;
    logic [IDX_W-1:0]    idx;
    logic [LANE_W-1:0]   data_q;
`ifdef HIER_LANE_SEQ_PARITY_EN
    logic                par_q;
`endif

    logic [N_LANES-1:0]  scan_mask;
    logic [IDX_W-1:0]    next_idx;
    logic [IDX_W-1:0]    low_idx;
    logic                has_next;
    logic                start_fire;
    logic                emit_adv;
    logic [LANE_W-1:0]   word;

    // In IDLE the scanner looks at the incoming mask, otherwise at the captured one.
    assign scan_mask  = (state == IDLE) ? bus.lane_mask : cap_mask;
    assign start_fire = (state == IDLE) && bus.start_valid;
    assign emit_adv   = (state == EMIT) && !bus.flush && bus.out_ready && has_next;

    hier_lane_seq_next u_next (
        .mask     (scan_mask),
        .cur      (idx),
        .next_idx (next_idx),
        .has_next (has_next),
        .low_idx  (low_idx)
    );

    always_comb begin
        word = '0;
        if (start_fire) begin
            word = laneWord(low_idx, bus.a, bus.b, C_LANE, D_LANE, SEXT);
        end else begin
            word = laneWord(next_idx, cap_a, cap_b, C_LANE, D_LANE, SEXT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Flush wins over out_ready; a zero mask skips straight to FIN.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (bus.start_valid) begin
                    state_nx = (bus.lane_mask != '0) ? EMIT : FIN;
                end
            end
            EMIT: begin
                if (bus.flush) begin
                    state_nx = FIN;
                end else if (bus.out_ready && !has_next) begin
                    state_nx = FIN;
                end
            end
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_a    <= '0;
            cap_b    <= '0;
            cap_mask <= '0;
            idx      <= '0;
            data_q   <= '0;
        end else if (start_fire) begin
            cap_a    <= bus.a;
            cap_b    <= bus.b;
            cap_mask <= bus.lane_mask;
            idx      <= low_idx;
            data_q   <= word;
        end else if (emit_adv) begin
            idx      <= next_idx;
            data_q   <= word;
        end
    end

`ifdef HIER_LANE_SEQ_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else if (start_fire || emit_adv) begin
            par_q <= ^word;
        end
    end
    assign bus.out_par = par_q;
`endif

    assign bus.start_ready = (state == IDLE);
    assign bus.out_valid   = (state == EMIT);
    assign bus.out_data    = data_q;
    assign bus.out_idx     = idx;
    assign bus.out_last    = (state == EMIT) && !has_next;
    assign bus.done        = (state == FIN);
    assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_hier_lane_sequencer.sv
// Directed bench for hier_lane_sequencer: zero- and sign-extending instances side by side.
// Parity checks are compiled in with HIER_LANE_SEQ_PARITY_EN.
module tb_hier_lane_sequencer;

    typedef struct {
        logic       sv;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] mask;
        logic       fl;
        logic       ordy;
        logic       e_valid;
        logic [1:0] e_idx;
        logic [7:0] e_data;
        logic [7:0] e_data_s;
        logic       e_last;
        logic       e_done;
        logic       e_busy;
        logic       e_sr;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   compared = 0;
    int   mismatched = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    hier_lane_sequencer_if ifc0 ();
    hier_lane_sequencer_if ifc1 ();

    assign ifc1.start_valid = ifc0.start_valid;
    assign ifc1.a           = ifc0.a;
    assign ifc1.b           = ifc0.b;
    assign ifc1.lane_mask   = ifc0.lane_mask;
    assign ifc1.flush       = ifc0.flush;
    assign ifc1.out_ready   = ifc0.out_ready;

    hier_lane_sequencer #(.C_VAL(-1), .D_VAL(8'hFF), .B_SEXT(0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc0)
    );

    hier_lane_sequencer #(.C_VAL(-1), .D_VAL(8'hFF), .B_SEXT(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc1)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        ifc0.start_valid = v.sv;
        ifc0.a           = v.a;
        ifc0.b           = v.b;
        ifc0.lane_mask   = v.mask;
        ifc0.flush       = v.fl;
        ifc0.out_ready   = v.ordy;
    endtask

    task automatic addVec(input logic sv, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] mask, input logic fl, input logic ordy,
                          input logic ev, input logic [1:0] ei, input logic [7:0] ed,
                          input logic [7:0] eds, input logic el, input logic edn,
                          input logic eb, input logic esr);
        vec_t v;
        v = '{sv, a, b, mask, fl, ordy, ev, ei, ed, eds, el, edn, eb, esr};
        vecs.push_back(v);
    endtask

    task automatic idleCheck(input string tag);
        checkOutput({tag, ".out_valid"}, 32'(ifc0.out_valid), 32'd0);
        checkOutput({tag, ".done"},      32'(ifc0.done),      32'd0);
        checkOutput({tag, ".busy"},      32'(ifc0.busy),      32'd0);
        checkOutput({tag, ".out_data"},  32'(ifc0.out_data),  32'd0);
        checkOutput({tag, ".out_idx"},   32'(ifc0.out_idx),   32'd0);
        checkOutput({tag, ".out_last"},  32'(ifc0.out_last),  32'd0);
    endtask

    initial begin
        ifc0.start_valid = 1'b0;
        ifc0.a           = 4'h0;
        ifc0.b           = 4'h0;
        ifc0.lane_mask   = 4'h0;
        ifc0.flush       = 1'b0;
        ifc0.out_ready   = 1'b0;

        // Full mask, consumer always ready.
        //     sv a    b    mask fl ordy  ev idx  data   data_s last done busy sr
        addVec(1, 4'h3, 4'hD, 4'hF, 0, 1,  0, 2'd0, 8'h00, 8'h00, 0, 0, 0, 1);
        addVec(0, 4'h0, 4'h0, 4'h0, 0, 1,  1, 2'd0, 8'h03, 8'h03, 0, 0, 1, 0);
        addVec(0, 4'h0, 4'h0, 4'h0, 0, 1,  1, 2'd1, 8'h0D, 8'hFD, 0, 0, 1, 0);
        addVec(0, 4'h0, 4'h0, 4'h0, 0, 1,  1, 2'd2, 8'hFF, 8'hFF, 0, 0, 1, 0);
        addVec(0, 4'h0, 4'h0, 4'h0, 0, 1,  1, 2'd3, 8'hFF, 8'hFF, 1, 0, 1, 0);
        addVec(0, 4'h0, 4'h0, 4'h0, 0, 1,  0, 2'd0, 8'h00, 8'h00, 0, 1, 1, 0);
        addVec(0, 4'h0, 4'h0, 4'h0, 0, 1,  0, 2'd0, 8'h00, 8'h00, 0, 0, 0, 1);
        // Sparse mask with backpressure; operands change after capture.
        addVec(1, 4'h5, 4'h9, 4'hA, 0, 0,  0, 2'd0, 8'h00, 8'h00, 0, 0, 0, 1);
        addVec(0, 4'hF, 4'hF, 4'h0, 0, 0,  1, 2'd1, 8'h09, 8'hF9, 0, 0, 1, 0);
        addVec(0, 4'hF, 4'hF, 4'h0, 0, 0,  1, 2'd1, 8'h09, 8'hF9, 0, 0, 1, 0);
        addVec(0, 4'hF, 4'hF, 4'h0, 0, 0,  1, 2'd1, 8'h09, 8'hF9, 0, 0, 1, 0);
        addVec(0, 4'hF, 4'hF, 4'h0, 0, 1,  1, 2'd1, 8'h09, 8'hF9, 0, 0, 1, 0);
        addVec(0, 4'hF, 4'hF, 4'h0, 0, 1,  1, 2'd3, 8'hFF, 8'hFF, 1, 0, 1, 0);
        addVec(0, 4'h0, 4'h0, 4'h0, 0, 1,  0, 2'd0, 8'h00, 8'h00, 0, 1, 1, 0);
        addVec(0, 4'h0, 4'h0, 4'h0, 0, 1,  0, 2'd0, 8'h00, 8'h00, 0, 0, 0, 1);
        // Zero mask with flush asserted alongside start and again in FIN.
        addVec(1, 4'h1, 4'h2, 4'h0, 1, 1,  0, 2'd0, 8'h00, 8'h00, 0, 0, 0, 1);
        addVec(0, 4'h0, 4'h0, 4'h0, 1, 1,  0, 2'd0, 8'h00, 8'h00, 0, 1, 1, 0);
        addVec(0, 4'h0, 4'h0, 4'h0, 0, 1,  0, 2'd0, 8'h00, 8'h00, 0, 0, 0, 1);
        // Flush on the second word, then a restart attempted in FIN and retried in IDLE.
        addVec(1, 4'h3, 4'hD, 4'hF, 0, 1,  0, 2'd0, 8'h00, 8'h00, 0, 0, 0, 1);
        addVec(0, 4'h0, 4'h0, 4'h0, 0, 1,  1, 2'd0, 8'h03, 8'h03, 0, 0, 1, 0);
        addVec(0, 4'h0, 4'h0, 4'h0, 1, 1,  1, 2'd1, 8'h0D, 8'hFD, 0, 0, 1, 0);
        addVec(1, 4'h0, 4'h0, 4'h4, 0, 1,  0, 2'd0, 8'h00, 8'h00, 0, 1, 1, 0);
        addVec(1, 4'h0, 4'h0, 4'h4, 0, 1,  0, 2'd0, 8'h00, 8'h00, 0, 0, 0, 1);
        addVec(0, 4'h0, 4'h0, 4'h0, 0, 1,  1, 2'd2, 8'hFF, 8'hFF, 1, 0, 1, 0);
        addVec(0, 4'h0, 4'h0, 4'h0, 0, 1,  0, 2'd0, 8'h00, 8'h00, 0, 1, 1, 0);
        addVec(0, 4'h0, 4'h0, 4'h0, 0, 1,  0, 2'd0, 8'h00, 8'h00, 0, 0, 0, 1);

        @(negedge clk);
        idleCheck("reset");
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset.start_ready", 32'(ifc0.start_ready), 32'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            checkOutput($sformatf("v%0d.out_valid", i),   32'(ifc0.out_valid),   32'(vecs[i].e_valid));
            checkOutput($sformatf("v%0d.done", i),        32'(ifc0.done),        32'(vecs[i].e_done));
            checkOutput($sformatf("v%0d.busy", i),        32'(ifc0.busy),        32'(vecs[i].e_busy));
            checkOutput($sformatf("v%0d.start_ready", i), 32'(ifc0.start_ready), 32'(vecs[i].e_sr));
            if (vecs[i].e_valid) begin
                checkOutput($sformatf("v%0d.out_idx", i),    32'(ifc0.out_idx),  32'(vecs[i].e_idx));
                checkOutput($sformatf("v%0d.out_data", i),   32'(ifc0.out_data), 32'(vecs[i].e_data));
                checkOutput($sformatf("v%0d.out_data_s", i), 32'(ifc1.out_data), 32'(vecs[i].e_data_s));
                checkOutput($sformatf("v%0d.out_last", i),   32'(ifc0.out_last), 32'(vecs[i].e_last));
            end
        end

        // Reset in the middle of EMIT drops everything with no done pulse.
        @(negedge clk);
        ifc0.start_valid = 1'b1; ifc0.a = 4'h3; ifc0.b = 4'hD; ifc0.lane_mask = 4'hF;
        ifc0.flush = 1'b0; ifc0.out_ready = 1'b0;
        @(negedge clk);
        ifc0.start_valid = 1'b0;
        checkOutput("rstmid.pre_valid", 32'(ifc0.out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        idleCheck("rstmid");
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput($sformatf("rstmid.c%0d.done", k),        32'(ifc0.done),        32'd0);
            checkOutput($sformatf("rstmid.c%0d.start_ready", k), 32'(ifc0.start_ready), 32'd1);
        end

`ifdef HIER_LANE_SEQ_PARITY_EN
        @(negedge clk);
        ifc0.start_valid = 1'b1; ifc0.a = 4'h7; ifc0.b = 4'h0; ifc0.lane_mask = 4'h1;
        ifc0.out_ready = 1'b0;
        @(negedge clk);
        ifc0.start_valid = 1'b0;
        checkOutput("par.out_data", 32'(ifc0.out_data), 32'h07);
        checkOutput("par.out_par",  32'(ifc0.out_par),  32'd1);
        ifc0.out_ready = 1'b1;
        @(negedge clk);
        checkOutput("par.done", 32'(ifc0.done), 32'd1);
        @(negedge clk);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
